// File: rtl/bsg_link_oddr_phy_sched.sv
// Transmit scheduler sharing one DDR output PHY between num_ch_p credit-gated channels.
// Optional per-channel grant statistics: define BSG_LINK_SCHED_STATS_EN.
module bsg_link_oddr_phy_sched #(
    parameter int unsigned num_ch_p        = 4,
    parameter int unsigned payload_width_p = 29,
    parameter int unsigned credit_p        = 8,
    parameter int unsigned train_words_p   = 16,
    localparam int unsigned lg_ch_lp       = $clog2(num_ch_p),
    localparam int unsigned phy_width_lp   = payload_width_p + lg_ch_lp + 1,
    localparam int unsigned lg_credit_lp   = $clog2(credit_p + 1)
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic [num_ch_p-1:0]                 ch_v_i,
    input  logic [num_ch_p*payload_width_p-1:0] ch_data_i,
    output logic [num_ch_p-1:0]                 ch_yumi_o,
    input  logic                                credit_v_i,
    input  logic [lg_ch_lp-1:0]                 credit_ch_i,
    input  logic                                phy_ready_i,
    output logic [phy_width_lp-1:0]             phy_data_o,
    output logic                                link_up_o,
    output logic                                credit_err_o,
    output logic [num_ch_p*16-1:0]              stat_grants_o
);

    localparam int unsigned lg_train_lp = (train_words_p > 1) ? $clog2(train_words_p) : 1;

    // Training pattern: MSB (valid) clear, odd bit positions set (0x2AAAAAAA at 32 bits).
    function automatic logic [phy_width_lp-1:0] train_word_f();
        logic [phy_width_lp-1:0] w;
        w = '0;
        for (int k = 1; k < int'(phy_width_lp) - 1; k += 2) begin
            w[k] = 1'b1;
        end
        return w;
    endfunction

    localparam logic [phy_width_lp-1:0] train_word_lp = train_word_f();
    localparam logic [lg_credit_lp-1:0] credit_full_lp = lg_credit_lp'(credit_p);
    localparam logic [lg_train_lp-1:0]  train_last_lp  = lg_train_lp'(train_words_p - 1);

    typedef enum logic {
        e_train,
        e_run
    } state_e;

    state_e                  state_r, state_n;
    logic [lg_train_lp-1:0]  train_cnt_r, train_cnt_n;
    logic [lg_ch_lp-1:0]     ptr_r, ptr_n;
    logic [lg_credit_lp-1:0] credit_r [num_ch_p];
    logic                    credit_err_r;
    logic [num_ch_p-1:0]     eligible;
    logic [num_ch_p-1:0]     credit_ret;
    logic [num_ch_p-1:0]     credit_full;
    logic                    credit_err_set;
    logic                    grant_v;
    logic [lg_ch_lp-1:0]     grant_id;
    logic [lg_ch_lp-1:0]     search_idx;

    always_comb begin
        for (int unsigned i = 0; i < num_ch_p; i++) begin
            eligible[i]    = ch_v_i[i] && (credit_r[i] != '0);
            credit_ret[i]  = credit_v_i && (credit_ch_i == lg_ch_lp'(i));
            credit_full[i] = (credit_r[i] == credit_full_lp);
        end
    end

    // A return to a full counter is only legal when the same channel is granted that cycle.
    assign credit_err_set = |(credit_ret & credit_full & ~ch_yumi_o);

    // Next state, round-robin arbitration and PHY word mux.
    always_comb begin
        state_n     = state_r;
        train_cnt_n = train_cnt_r;
        ptr_n       = ptr_r;
        grant_v     = 1'b0;
        grant_id    = '0;
        search_idx  = '0;
        ch_yumi_o   = '0;
        phy_data_o  = '0;
        case (state_r)
            e_train: begin
                phy_data_o = train_word_lp;
                if (phy_ready_i) begin
                    if (train_cnt_r == train_last_lp) begin
                        state_n = e_run;
                    end else begin
                        train_cnt_n = train_cnt_r + lg_train_lp'(1);
                    end
                end
            end
            e_run: begin
                // Gated by reset so a word being dropped is never acknowledged.
                if (phy_ready_i && reset_n_i) begin
                    for (int unsigned off = 1; off <= num_ch_p; off++) begin
                        search_idx = ptr_r + lg_ch_lp'(off);
                        if (!grant_v && eligible[search_idx]) begin
                            grant_v  = 1'b1;
                            grant_id = search_idx;
                        end
                    end
                end
                if (grant_v) begin
                    ch_yumi_o[grant_id] = 1'b1;
                    phy_data_o = {1'b1, grant_id,
                                  ch_data_i[grant_id*payload_width_p +: payload_width_p]};
                    ptr_n = grant_id;
                end
            end
            default: state_n = e_train;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_r      <= e_train;
            train_cnt_r  <= '0;
            ptr_r        <= lg_ch_lp'(num_ch_p - 1);
            credit_err_r <= 1'b0;
        end else begin
            state_r     <= state_n;
            train_cnt_r <= train_cnt_n;
            ptr_r       <= ptr_n;
            if (credit_err_set) begin
                credit_err_r <= 1'b1;
            end
        end
    end

    // Per-channel credit counters; simultaneous grant and return cancel out.
    for (genvar i = 0; i < num_ch_p; i++) begin : g_credit
        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                credit_r[i] <= credit_full_lp;
            end else if (credit_ret[i] && !ch_yumi_o[i]) begin
                if (!credit_full[i]) begin
                    credit_r[i] <= credit_r[i] + lg_credit_lp'(1);
                end
            end else if (!credit_ret[i] && ch_yumi_o[i]) begin
                credit_r[i] <= credit_r[i] - lg_credit_lp'(1);
            end
        end
    end

    assign link_up_o    = (state_r == e_run);
    assign credit_err_o = credit_err_r;

`ifdef BSG_LINK_SCHED_STATS_EN
    for (genvar i = 0; i < num_ch_p; i++) begin : g_stat
        logic [15:0] stat_r;
        always_ff @(posedge clk_i) begin
            if (!reset_n_i) begin
                stat_r <= '0;
            end else if (ch_yumi_o[i]) begin
                stat_r <= stat_r + 16'd1;
            end
        end
        assign stat_grants_o[i*16 +: 16] = stat_r;
    end
`else
    assign stat_grants_o = '0;
`endif

endmodule

// File: tb/tb_bsg_link_oddr_phy_sched.sv
// Scoreboard bench for bsg_link_oddr_phy_sched: one expected entry per cycle, checked at negedge.
module tb_bsg_link_oddr_phy_sched;

    localparam logic [31:0] TW = 32'h2AAA_AAAA;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [3:0]   ch_v = '0;
    logic [115:0] ch_data;
    logic [3:0]   ch_yumi;
    logic         credit_v = 1'b0;
    logic [1:0]   credit_ch = '0;
    logic         phy_ready = 1'b0;
    logic [31:0]  phy_data;
    logic         link_up;
    logic         credit_err;
    logic [63:0]  stat_grants;

    typedef struct packed {
        logic [31:0] word;
        logic [3:0]  yumi;
        logic        link;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;

    bsg_link_oddr_phy_sched dut (
        .clk_i         (clk),
        .reset_n_i     (reset_n),
        .ch_v_i        (ch_v),
        .ch_data_i     (ch_data),
        .ch_yumi_o     (ch_yumi),
        .credit_v_i    (credit_v),
        .credit_ch_i   (credit_ch),
        .phy_ready_i   (phy_ready),
        .phy_data_o    (phy_data),
        .link_up_o     (link_up),
        .credit_err_o  (credit_err),
        .stat_grants_o (stat_grants)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at %0t: observed 0x%0h expected 0x%0h", tag, $time, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus and queue what the DUT must show in that cycle.
    task automatic slot(input logic rst, input logic rdy, input logic [3:0] v,
                        input logic cv, input logic [1:0] cch,
                        input logic [31:0] w, input logic [3:0] y,
                        input logic lk, input logic er);
        exp_t e;
        @(posedge clk);
        #1;
        reset_n   = rst;
        phy_ready = rdy;
        ch_v      = v;
        credit_v  = cv;
        credit_ch = cch;
        e.word = w;
        e.yumi = y;
        e.link = lk;
        e.err  = er;
        exp_q.push_back(e);
    endtask

    // 16 training words on alternate ready cycles; link is up in the cycle after the 16th accept.
    task automatic train(input logic [3:0] v);
        for (int k = 0; k < 32; k++) begin
            if (k < 31) slot(1'b1, (k % 2) == 0, v, 1'b0, 2'd0, TW, 4'b0000, 1'b0, 1'b0);
            else        slot(1'b1, 1'b0, v, 1'b0, 2'd0, 32'h0, 4'b0000, 1'b1, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            cur = exp_q.pop_front();
            check("phy_data", 64'(phy_data), 64'(cur.word));
            check("ch_yumi", 64'(ch_yumi), 64'(cur.yumi));
            check("link_up", 64'(link_up), 64'(cur.link));
            check("credit_err", 64'(credit_err), 64'(cur.err));
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rr_w [5];
        logic [3:0]  rr_y [5];
        logic [63:0] stat_exp;
        rr_w = '{32'h8000_0100, 32'hA000_0101, 32'hC000_0102, 32'hE000_0103, 32'h8000_0100};
        rr_y = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        ch_data = {29'h103, 29'h102, 29'h101, 29'h100};

        // Reset, training with no requests, then an idle word on a ready slot.
        slot(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, TW, 4'b0000, 1'b0, 1'b0);
        slot(1'b0, 1'b0, 4'b0000, 1'b0, 2'd0, TW, 4'b0000, 1'b0, 1'b0);
        train(4'b0000);
        slot(1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0, 4'b0000, 1'b1, 1'b0);

        // All channels requesting: round-robin 0,1,2,3,0 on ready slots.
        for (int n = 0; n < 10; n++) begin
            if ((n % 2) == 0) slot(1'b1, 1'b1, 4'b1111, 1'b0, 2'd0, rr_w[n/2], rr_y[n/2], 1'b1, 1'b0);
            else              slot(1'b1, 1'b0, 4'b1111, 1'b0, 2'd0, 32'h0, 4'b0000, 1'b1, 1'b0);
        end

        // Mid-RUN reset with requests pending: no yumi, then training restarts.
        slot(1'b0, 1'b1, 4'b1111, 1'b0, 2'd0, 32'h0, 4'b0000, 1'b1, 1'b0);
        train(4'b1111);

        // Channel 1 alone: exactly 8 grants from refilled credits, then starvation.
        for (int n = 0; n < 18; n++) begin
            if ((n % 2) == 0 && n < 16)
                slot(1'b1, 1'b1, 4'b0010, 1'b0, 2'd0, 32'hA000_0101, 4'b0010, 1'b1, 1'b0);
            else
                slot(1'b1, (n % 2) == 0, 4'b0010, 1'b0, 2'd0, 32'h0, 4'b0000, 1'b1, 1'b0);
        end
        slot(1'b1, 1'b0, 4'b0010, 1'b1, 2'd1, 32'h0, 4'b0000, 1'b1, 1'b0);
        slot(1'b1, 1'b1, 4'b0010, 1'b0, 2'd0, 32'hA000_0101, 4'b0010, 1'b1, 1'b0);
        slot(1'b1, 1'b0, 4'b0010, 1'b0, 2'd0, 32'h0, 4'b0000, 1'b1, 1'b0);
        slot(1'b1, 1'b1, 4'b0010, 1'b0, 2'd0, 32'h0, 4'b0000, 1'b1, 1'b0);

        // Grant and return on ch0 together: credit stays 8, so 8 more grants follow.
        slot(1'b1, 1'b1, 4'b0001, 1'b1, 2'd0, 32'h8000_0100, 4'b0001, 1'b1, 1'b0);
        for (int n = 0; n < 18; n++) begin
            if ((n % 2) == 1 && n < 16)
                slot(1'b1, 1'b1, 4'b0001, 1'b0, 2'd0, 32'h8000_0100, 4'b0001, 1'b1, 1'b0);
            else
                slot(1'b1, (n % 2) == 1, 4'b0001, 1'b0, 2'd0, 32'h0, 4'b0000, 1'b1, 1'b0);
        end

        // Return to full ch3 sets the sticky error; a normal ch0 return still works after.
        slot(1'b1, 1'b0, 4'b0000, 1'b1, 2'd3, 32'h0, 4'b0000, 1'b1, 1'b0);
        slot(1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0, 4'b0000, 1'b1, 1'b1);
        slot(1'b1, 1'b0, 4'b0000, 1'b1, 2'd0, 32'h0, 4'b0000, 1'b1, 1'b1);
        slot(1'b1, 1'b1, 4'b0001, 1'b0, 2'd0, 32'h8000_0100, 4'b0001, 1'b1, 1'b1);
        slot(1'b1, 1'b0, 4'b0000, 1'b0, 2'd0, 32'h0, 4'b0000, 1'b1, 1'b1);
        slot(1'b1, 1'b1, 4'b0000, 1'b0, 2'd0, 32'h0, 4'b0000, 1'b1, 1'b1);

        @(negedge clk);
        #1;
`ifdef BSG_LINK_SCHED_STATS_EN
        stat_exp = {16'd0, 16'd0, 16'd9, 16'd10};
`else
        stat_exp = 64'd0;
`endif
        check("stat_grants", stat_grants, stat_exp);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
